and_chain_bist: RTL
===================

AND_CHAIN_BIST -- requirements
Module: and_chain_bist

Interface
REQ-001 Parameter LENGTH, default 4: width of the driven vector (LENGTH >= 1).
REQ-002 Parameter SETTLE, default 1: wait cycles after each new vector before y is sampled (SETTLE >= 1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a full test run.
REQ-006 x_out  output  LENGTH  vector driven to the AND-chain under test.
REQ-007 y_in  input  1  AND-chain result returned from the unit under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next accepted start or reset.
REQ-010 pass  output  1  valid while done=1; high iff no mismatches were recorded.
REQ-011 err_count  output  LENGTH+1  number of mismatching vectors in the current or last run.
REQ-012 first_fail  output  LENGTH  first vector that mismatched; valid when err_count != 0.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, FINISH.
REQ-014 IDLE: start=1 -> x_out<=0, err_count<=0, first_fail<=0, done<=0, pass<=0, busy<=1, settle counter loaded, go to SETTLE.
REQ-015 SETTLE: hold x_out for exactly SETTLE cycles, then go to SAMPLE.
REQ-016 SAMPLE (1 cycle): expected = AND-reduction of x_out; y_in != expected -> err_count increments; first_fail <= x_out only if err_count was 0.
REQ-017 SAMPLE with x_out != all-ones: x_out increments by 1, settle counter reloads, go to SETTLE.
REQ-018 SAMPLE with x_out == all-ones: no wrap, x_out holds; go to FINISH.
REQ-019 FINISH: busy<=0, done<=1, pass<=(err_count==0 including the final sample), then go to IDLE; done/pass/err_count/first_fail hold until the next accepted start.
REQ-020 Timing: start accepted at edge 0; vector k is sampled at edge (k+1)*(SETTLE+1); done rises one edge after the final sample, at edge 2^LENGTH*(SETTLE+1)+1.
REQ-021 start is ignored while busy=1; start in the same cycle as rst is ignored.
REQ-022 err_count never wraps; its maximum value 2^LENGTH fits in LENGTH+1 bits.
REQ-023 All outputs are registered; there is no combinational path from y_in or start to any output.

Reset
REQ-024 When rst=1 on a clock edge, the block enters IDLE with x_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, and the settle counter at 0.
REQ-025 Reset during a run aborts the run immediately; no partial result survives; the next start runs a full sequence from vector 0.

Structure
REQ-026 Shared package and_chain_pkg holds the FSM state encoding and the default LENGTH and SETTLE constants.
REQ-027 One sub-module, bist_settle_timer (load, count down, expire flag, width = clog2(SETTLE+1)), implements the settle counter.
REQ-028 The expected-value computation is inline AND-reduction; no duplicate instance of the unit under test sits inside this block.

Verification
REQ-029 LENGTH=4, SETTLE=1, y_in driven by a correct 4-input AND chain, start pulsed -> done=1 at edge 33, pass=1, err_count=0, busy low from edge 33.
REQ-030 Same setup, y_in stuck at 0 -> err_count=1, first_fail=4'hF, pass=0.
REQ-031 Same setup, y_in stuck at 1 -> err_count=15, first_fail=4'h0, pass=0.
REQ-032 rst asserted while x_out=5 -> next edge gives all outputs at reset values and IDLE; a new start then completes a clean run with pass=1 at edge 33 after start.
REQ-033 start re-pulsed at x_out=3 during a run -> no restart; completion timing is unchanged at edge 33.
REQ-034 LENGTH=3, SETTLE=3, correct chain -> each vector is held for 4 cycles, done=1 at edge 33, pass=1.

Source files
------------

// File: rtl/and_chain_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | and_chain_pkg : FSM encoding and default sizes for and_chain_bist |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package and_chain_pkg;

    localparam int unsigned DEF_LENGTH = 4;
    localparam int unsigned DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bist_settle_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bist_settle_timer : loadable down-counter, flags last settle cycle|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module bist_settle_timer #(
    parameter int SETTLE = 1,
    parameter int W      = $clog2(SETTLE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(SETTLE);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted on the final hold cycle so the FSM leaves SETTLE on that edge.
    assign expire_o = (cnt_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/and_chain_bist.sv
`default_nettype none
// +------------------------------------------------------------------+
// | and_chain_bist : exhaustive self-test of an external AND chain    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module and_chain_bist
    import and_chain_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [LENGTH-1:0] x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LENGTH:0]   err_count,
    output logic [LENGTH-1:0] first_fail
);

    state_e            state_q;
    logic [LENGTH-1:0] x_q;
    logic [LENGTH-1:0] ff_q;
    logic [LENGTH:0]   err_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic w_all_ones;
    logic w_mismatch;
    logic w_tmr_load;
    logic w_tmr_en;
    logic w_tmr_expire;

    // The AND of the vector is both the expected chain output and the end-of-sweep marker.
    assign w_all_ones = &x_q;
    assign w_mismatch = (y_in != w_all_ones);
    assign w_tmr_load = ((state_q == ST_IDLE) && start) ||
                        ((state_q == ST_SAMPLE) && !w_all_ones);
    assign w_tmr_en   = (state_q == ST_SETTLE);

    bist_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_tmr_load),
        .en_i     (w_tmr_en),
        .expire_o (w_tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            ff_q    <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q     <= '0;
                        ff_q    <= '0;
                        err_q   <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_expire) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (err_q == '0) begin
                            ff_q <= x_q;
                        end
                    end
                    if (w_all_ones) begin
                        state_q <= ST_FINISH;
                    end else begin
                        x_q     <= x_q + 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x_out      = x_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
`default_nettype wire
